// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// Data-memory access stage: request/grant/valid bus master with store lane alignment and load extension.
// Define MISALIGN_TRAP_EN to abort misaligned halfword/word accesses with ERR instead of issuing them.
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [3:0]  BE,
    input  logic [2:0]  funct3,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        DONE,
    output logic        BUSY,
    output logic        ERR,
    output logic        D_REQ,
    output logic        D_WE,
    output logic [31:0] D_ADDR,
    output logic [3:0]  D_BE,
    output logic [31:0] D_WDATA,
    input  logic        D_GNT,
    input  logic        D_RVALID,
    input  logic [31:0] D_RDATA
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FIN,
        S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   d_addr_q, d_wdata_q;
    logic [3:0]    d_be_q;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic          we_q;
    logic          capture;

    logic          start;
    logic          misaligned;
    logic [3:0]    be_shift;
    logic [31:0]   wdata_shift;
    logic [31:0]   load_x;
    logic [31:0]   load_ext;

    assign start       = MemRead | MemWrite;
    assign be_shift    = BE << ADDR[1:0];
    assign wdata_shift = WDATA << {ADDR[1:0], 3'b000};

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((BE == 4'b0011) && ADDR[0]) ||
                        ((BE == 4'b1111) && (ADDR[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Load data is brought down to byte 0 using the captured offset, then extended.
    assign load_x = D_RDATA >> {off_q, 3'b000};

    always_comb begin
        load_ext = D_RDATA;
        case (f3_q)
            3'b000:  load_ext = {{24{load_x[7]}}, load_x[7:0]};
            3'b100:  load_ext = {24'd0, load_x[7:0]};
            3'b001:  load_ext = {{16{load_x[15]}}, load_x[15:0]};
            3'b101:  load_ext = {16'd0, load_x[15:0]};
            3'b010:  load_ext = load_x;
            default: load_ext = D_RDATA;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    if (BE == 4'b0000) begin
                        state_d = S_FIN;
                    end else if (misaligned) begin
                        state_d = S_FIN;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // A grant arriving on the last allowed cycle still wins over the timeout.
                if (D_GNT) begin
                    state_d = we_q ? S_FIN : S_WAIT;
                    cnt_d   = cnt_q + 1'b1;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (D_RVALID) begin
                    state_d = S_FIN;
                    rdata_d = load_ext;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = S_FIN;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            d_addr_q  <= '0;
            d_be_q    <= '0;
            d_wdata_q <= '0;
            off_q     <= '0;
            f3_q      <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (capture) begin
                d_addr_q  <= {ADDR[31:2], 2'b00};
                d_be_q    <= be_shift;
                d_wdata_q <= wdata_shift;
                off_q     <= ADDR[1:0];
                f3_q      <= funct3;
                we_q      <= MemWrite;
            end
        end
    end

    assign RDATA   = rdata_q;
    assign DONE    = (state_q == S_FIN);
    assign ERR     = (state_q == S_FIN) && err_q;
    assign BUSY    = (state_q != S_IDLE);
    assign D_REQ   = (state_q == S_REQ);
    assign D_WE    = (state_q == S_REQ) && we_q;
    assign D_ADDR  = d_addr_q;
    assign D_BE    = d_be_q;
    assign D_WDATA = d_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// Bench for mem_access_unit: directed cases plus randomized accesses against a behavioural model.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [3:0]  BE = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] ADDR = '0, WDATA = '0;
    logic [31:0] RDATA;
    logic        DONE, BUSY, ERR, D_REQ, D_WE;
    logic [31:0] D_ADDR, D_WDATA;
    logic [3:0]  D_BE;
    logic        D_GNT = 1'b0, D_RVALID = 1'b0;
    logic [31:0] D_RDATA = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rdata = '0;

    int          obs_done_c, obs_req_cnt;
    logic        obs_err, obs_busy1, obs_done2, obs_busy_after, obs_gwe;
    logic [31:0] obs_gaddr, obs_gwdata, obs_rdata;
    logic [3:0]  obs_gbe;

    mem_access_unit #(.TIMEOUT(15)) dut (
        .CLK(CLK), .RSTn(RSTn), .MemRead(MemRead), .MemWrite(MemWrite),
        .BE(BE), .funct3(funct3), .ADDR(ADDR), .WDATA(WDATA),
        .RDATA(RDATA), .DONE(DONE), .BUSY(BUSY), .ERR(ERR),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_BE(D_BE), .D_WDATA(D_WDATA),
        .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA)
    );

    always #5 CLK = ~CLK;

    // Behavioural reference: load result from the bus word, offset and funct3.
    function automatic logic [31:0] ref_load(input logic [31:0] bus, input logic [1:0] s, input logic [2:0] f3);
        logic [31:0] x;
        logic [31:0] b;
        logic [31:0] h;
        x = bus >> (8 * s);
        b = x & 32'hFF;
        h = x & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'h80)   ? b - 32'd256     : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'h8000) ? h - 32'h1_0000  : h;
            3'b101:  return h;
            3'b010:  return x;
            default: return bus;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [3:0] be, input logic [1:0] s);
        int t;
        t = (int'(be) * (1 << s)) % 16;
        return t[3:0];
    endfunction

    function automatic logic ref_misaligned(input logic [3:0] be, input logic [31:0] addr);
`ifdef MISALIGN_TRAP_EN
        return ((be == 4'b0011) && (addr % 2 != 0)) || ((be == 4'b1111) && (addr % 4 != 0));
`else
        return 1'b0;
`endif
    endfunction

    // Drives one access with the bus responding gd cycles late to the grant and rd cycles late to data.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be, input logic [2:0] f3,
                              input int gd, input int rdd, input logic [31:0] bus_rdata);
        @(posedge CLK); #1;
        MemRead = rd; MemWrite = wr; ADDR = addr; WDATA = wdata; BE = be; funct3 = f3;
        obs_done_c = -1; obs_req_cnt = 0; obs_err = 1'b0; obs_busy1 = 1'b0;
        obs_done2 = 1'b1; obs_busy_after = 1'b1; obs_gwe = 1'bx;
        obs_gaddr = 'x; obs_gbe = 'x; obs_gwdata = 'x; obs_rdata = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK); #1;
            D_GNT    = (c == 1 + gd);
            D_RVALID = (c == 2 + gd + rdd);
            D_RDATA  = D_RVALID ? bus_rdata : $urandom();
            if (c == 1) obs_busy1 = BUSY;
            if (D_REQ) obs_req_cnt++;
            if (c == 1 + gd) begin
                obs_gaddr = D_ADDR; obs_gbe = D_BE; obs_gwdata = D_WDATA; obs_gwe = D_WE;
            end
            if (obs_done_c < 0 && DONE) begin
                obs_done_c = c; obs_err = ERR; obs_rdata = RDATA;
            end else if (obs_done_c >= 0 && c == obs_done_c + 1) begin
                obs_done2 = DONE; MemRead = 1'b0; MemWrite = 1'b0;
            end else if (obs_done_c >= 0 && c == obs_done_c + 2) begin
                obs_busy_after = BUSY;
                break;
            end
        end
        D_GNT = 1'b0; D_RVALID = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (DONE !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b0) begin errors++;
            $display("FAIL reset_status got DONE=%b BUSY=%b ERR=%b exp 0 0 0", DONE, BUSY, ERR); end
        checks++; if (D_REQ !== 1'b0 || D_WE !== 1'b0 || D_BE !== 4'b0) begin errors++;
            $display("FAIL reset_bus_ctrl got REQ=%b WE=%b BE=%b exp 0 0 0000", D_REQ, D_WE, D_BE); end
        checks++; if (D_ADDR !== 32'd0 || D_WDATA !== 32'd0 || RDATA !== 32'd0) begin errors++;
            $display("FAIL reset_data got ADDR=%h WDATA=%h RDATA=%h exp 0", D_ADDR, D_WDATA, RDATA); end
        RSTn = 1'b1;
        @(posedge CLK);
    endtask

    task automatic test_lb_sign();
        run_access(1'b1, 1'b0, 32'h0000_1003, 32'h0, 4'b0001, 3'b000, 0, 0, 32'h80AA_BBCC);
        checks++; if (obs_done_c !== 3) begin errors++;
            $display("FAIL lb_done_cycle got %0d exp 3", obs_done_c); end
        checks++; if (obs_gaddr !== 32'h0000_1000 || obs_gbe !== 4'b1000) begin errors++;
            $display("FAIL lb_bus got ADDR=%h BE=%b exp 00001000 1000", obs_gaddr, obs_gbe); end
        checks++; if (obs_rdata !== 32'hFFFF_FF80 || obs_err !== 1'b0) begin errors++;
            $display("FAIL lb_rdata got %h err=%b exp ffffff80 err=0", obs_rdata, obs_err); end
        model_rdata = 32'hFFFF_FF80;
    endtask

    task automatic test_sh_stall();
        run_access(1'b0, 1'b1, 32'h0000_2002, 32'h0000_1234, 4'b0011, 3'b001, 3, 0, 32'h0);
        checks++; if (obs_done_c !== 5 || obs_err !== 1'b0) begin errors++;
            $display("FAIL sh_done got cycle %0d err=%b exp 5 err=0", obs_done_c, obs_err); end
        checks++; if (obs_gbe !== 4'b1100 || obs_gwdata !== 32'h1234_0000 || obs_gwe !== 1'b1) begin errors++;
            $display("FAIL sh_bus got BE=%b WDATA=%h WE=%b exp 1100 12340000 1", obs_gbe, obs_gwdata, obs_gwe); end
        checks++; if (obs_req_cnt !== 4 || obs_rdata !== model_rdata) begin errors++;
            $display("FAIL sh_req_rdata got req=%0d rdata=%h exp 4 %h", obs_req_cnt, obs_rdata, model_rdata); end
    endtask

    task automatic test_lhu();
        run_access(1'b1, 1'b0, 32'h0000_0002, 32'h0, 4'b0011, 3'b101, 1, 2, 32'hF00D_0000);
        checks++; if (obs_rdata !== 32'h0000_F00D || obs_done_c !== 6) begin errors++;
            $display("FAIL lhu got rdata=%h cycle %0d exp 0000f00d 6", obs_rdata, obs_done_c); end
        model_rdata = 32'h0000_F00D;
    endtask

    task automatic test_grant_at_timeout();
        run_access(1'b0, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 3'b010, 14, 0, 32'h0);
        checks++; if (obs_done_c !== 16 || obs_err !== 1'b0) begin errors++;
            $display("FAIL grant_vs_timeout got cycle %0d err=%b exp 16 err=0", obs_done_c, obs_err); end
    endtask

    task automatic test_timeout();
        int req_cnt;
        int done_c;
        logic err_at_done;
        logic hold_ok;
        @(posedge CLK); #1;
        MemRead = 1'b1; ADDR = 32'h0000_0040; BE = 4'b1111; funct3 = 3'b010;
        req_cnt = 0; done_c = -1; err_at_done = 1'b0; hold_ok = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(posedge CLK); #1;
            if (D_REQ) req_cnt++;
            if (done_c < 0 && DONE) begin done_c = c; err_at_done = ERR; end
            if (c > 16 && (BUSY !== 1'b1 || DONE !== 1'b0 || D_REQ !== 1'b0)) hold_ok = 1'b0;
        end
        checks++; if (done_c !== 16 || err_at_done !== 1'b1) begin errors++;
            $display("FAIL timeout_done got cycle %0d err=%b exp 16 err=1", done_c, err_at_done); end
        checks++; if (req_cnt !== 15) begin errors++;
            $display("FAIL timeout_req_cycles got %0d exp 15", req_cnt); end
        checks++; if (hold_ok !== 1'b1) begin errors++;
            $display("FAIL timeout_hold got %b exp 1", hold_ok); end
        MemRead = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checks++; if (BUSY !== 1'b0) begin errors++;
            $display("FAIL timeout_release got BUSY=%b exp 0", BUSY); end
        MemRead = 1'b1;
        @(posedge CLK); #1;
        checks++; if (D_REQ !== 1'b1) begin errors++;
            $display("FAIL timeout_restart got D_REQ=%b exp 1", D_REQ); end
        D_GNT = 1'b1;
        @(posedge CLK); #1;
        D_GNT = 1'b0; D_RVALID = 1'b1; D_RDATA = 32'h1234_5678;
        @(posedge CLK); #1;
        D_RVALID = 1'b0;
        checks++; if (DONE !== 1'b1 || ERR !== 1'b0 || RDATA !== 32'h1234_5678) begin errors++;
            $display("FAIL timeout_followup got DONE=%b ERR=%b RDATA=%h exp 1 0 12345678", DONE, ERR, RDATA); end
        model_rdata = 32'h1234_5678;
        MemRead = 1'b0;
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_random();
        logic        rd, wr, is_wr, mis;
        logic [3:0]  be;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, bus;
        int          gd, rdd, sel, exp_done;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 2);
            rd = (sel != 1); wr = (sel != 0); is_wr = wr;
            case ($urandom_range(0, 7))
                0:       be = 4'b0000;
                1, 2:    be = 4'b0001;
                3, 4:    be = 4'b0011;
                default: be = 4'b1111;
            endcase
            addr = $urandom(); wdata = $urandom(); bus = $urandom();
            f3 = 3'($urandom_range(0, 7));
            gd = $urandom_range(0, 6); rdd = $urandom_range(0, 6);
            mis = ref_misaligned(be, addr);
            run_access(rd, wr, addr, wdata, be, f3, gd, rdd, bus);
            if (be == 4'b0000 || mis) begin
                exp_done = 1;
            end else begin
                exp_done = is_wr ? 2 + gd : 3 + gd + rdd;
            end
            checks++; if (obs_done_c !== exp_done || obs_err !== (mis && be != 4'b0000)) begin errors++;
                $display("FAIL rand%0d done got cycle %0d err=%b exp %0d err=%b", i, obs_done_c, obs_err, exp_done, mis); end
            checks++; if (obs_busy1 !== 1'b1 || obs_done2 !== 1'b0 || obs_busy_after !== 1'b0) begin errors++;
                $display("FAIL rand%0d busy_pulse got busy1=%b done2=%b busy_after=%b exp 1 0 0", i, obs_busy1, obs_done2, obs_busy_after); end
            if (be == 4'b0000 || mis) begin
                checks++; if (obs_req_cnt !== 0) begin errors++;
                    $display("FAIL rand%0d no_bus got req=%0d exp 0", i, obs_req_cnt); end
            end else begin
                checks++; if (obs_req_cnt !== gd + 1 || obs_gwe !== is_wr) begin errors++;
                    $display("FAIL rand%0d req got cnt=%0d we=%b exp %0d %b", i, obs_req_cnt, obs_gwe, gd + 1, is_wr); end
                checks++; if (obs_gaddr !== (addr & 32'hFFFF_FFFC) || obs_gbe !== ref_be(be, addr[1:0])) begin errors++;
                    $display("FAIL rand%0d bus_addr got %h/%b exp %h/%b", i, obs_gaddr, obs_gbe, addr & 32'hFFFF_FFFC, ref_be(be, addr[1:0])); end
                if (is_wr) begin
                    checks++; if (obs_gwdata !== (wdata << (8 * addr[1:0]))) begin errors++;
                        $display("FAIL rand%0d wdata got %h exp %h", i, obs_gwdata, wdata << (8 * addr[1:0])); end
                end else begin
                    model_rdata = ref_load(bus, addr[1:0], f3);
                end
            end
            checks++; if (obs_rdata !== model_rdata) begin errors++;
                $display("FAIL rand%0d rdata got %h exp %h", i, obs_rdata, model_rdata); end
        end
    endtask

    task automatic test_misalign();
        run_access(1'b1, 1'b0, 32'h0000_0001, 32'h0, 4'b1111, 3'b010, 0, 0, 32'hDEAD_BEEF);
`ifdef MISALIGN_TRAP_EN
        checks++; if (obs_done_c !== 1 || obs_err !== 1'b1 || obs_req_cnt !== 0) begin errors++;
            $display("FAIL misalign_trap got cycle %0d err=%b req=%0d exp 1 1 0", obs_done_c, obs_err, obs_req_cnt); end
`else
        checks++; if (obs_done_c !== 3 || obs_err !== 1'b0 || obs_gbe !== 4'b1110) begin errors++;
            $display("FAIL misalign_pass got cycle %0d err=%b be=%b exp 3 0 1110", obs_done_c, obs_err, obs_gbe); end
        checks++; if (obs_rdata !== 32'h00DE_ADBE) begin errors++;
            $display("FAIL misalign_rdata got %h exp 00deadbe", obs_rdata); end
        model_rdata = 32'h00DE_ADBE;
`endif
    endtask

    task automatic test_reset_mid_access();
        logic quiet;
        @(posedge CLK); #1;
        MemRead = 1'b1; ADDR = 32'h0000_0010; BE = 4'b1111; funct3 = 3'b010;
        @(posedge CLK); #1;
        D_GNT = 1'b1;
        @(posedge CLK); #1;
        D_GNT = 1'b0;
        checks++; if (BUSY !== 1'b1 || D_REQ !== 1'b0) begin errors++;
            $display("FAIL midrst_wait got BUSY=%b REQ=%b exp 1 0", BUSY, D_REQ); end
        RSTn = 1'b0; MemRead = 1'b0;
        @(posedge CLK); #1;
        RSTn = 1'b1;
        checks++; if ({RDATA, DONE, BUSY, ERR, D_REQ, D_WE, D_ADDR, D_BE, D_WDATA} !== '0) begin errors++;
            $display("FAIL midrst_outputs got RDATA=%h BUSY=%b ADDR=%h BE=%b exp all 0", RDATA, BUSY, D_ADDR, D_BE); end
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK); #1;
            D_RVALID = (c == 0); D_RDATA = 32'hFFFF_FFFF;
            if ({RDATA, DONE, BUSY, ERR, D_REQ, D_WE, D_ADDR, D_BE, D_WDATA} !== '0) quiet = 1'b0;
        end
        D_RVALID = 1'b0;
        checks++; if (quiet !== 1'b1) begin errors++;
            $display("FAIL midrst_late_rvalid got quiet=%b exp 1", quiet); end
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_sh_stall();
        test_lhu();
        test_grant_at_timeout();
        test_timeout();
        test_random();
        test_misalign();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
